// File: rtl/vending_pkg.sv
// Shared types and constants for the change-dispenser slice: coin codes,
// their face values and the payout FSM states.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2,
    COIN_50 = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Face value of each coin code, indexed by the code itself.
  localparam logic [7:0] COIN_VALUE [4] = '{8'd1, 8'd5, 8'd10, 8'd50};

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    return COIN_VALUE[code];
  endfunction

endpackage

// File: rtl/vending_coin_select.sv
// Priority picker: largest denomination that still fits the remaining
// amount and has at least one coin in stock.
module vending_coin_select
  import vending_pkg::*;
(
  input  logic [7:0] rem,
  input  logic [3:0] avail,
  output logic       found,
  output logic [1:0] code
);

  // Scan codes upward so the last hit, i.e. the largest usable coin, wins.
  always_comb begin
    found = 1'b0;
    code  = COIN_1;
    for (int i = 0; i < 4; i++) begin
      if (avail[i] && (coin_value(2'(i)) <= rem)) begin
        found = 1'b1;
        code  = 2'(i);
      end
    end
  end

endmodule

// File: rtl/vending_change_dispenser.sv
// Coin-payout engine: pays a change amount one coin at a time, largest
// denomination first, tracking per-denomination stock and reporting any
// amount that could not be paid.
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_STOCK = 8,
  parameter int STOCK_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] amt,
  input  logic       amt_valid,
  output logic       amt_ready,
  input  logic       refill,
  output logic [1:0] coin,
  output logic       coin_valid,
  input  logic       coin_ack,
  output logic       done,
  output logic       short,
  output logic [7:0] remain
);

  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  state_t             state;
  logic [7:0]         rem;
  logic [STOCK_W-1:0] stock [4];
  logic [3:0]         avail;
  logic               sel_found;
  logic [1:0]         sel_code;

  // A denomination is usable only while its stock counter is non-zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      avail[i] = (stock[i] != '0);
    end
  end

  vending_coin_select u_select (
    .rem   (rem),
    .avail (avail),
    .found (sel_found),
    .code  (sel_code)
  );

  assign amt_ready = (state == S_IDLE);

  // Payout FSM with rem, stock counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rem        <= 8'd0;
      coin       <= COIN_1;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      remain     <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        stock[i] <= STOCK_FULL;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Refill lands in the same edge as an accept, so SELECT sees it.
          if (refill) begin
            for (int i = 0; i < 4; i++) begin
              stock[i] <= STOCK_FULL;
            end
          end
          if (amt_valid) begin
            rem <= amt;
            if (amt == 8'd0) begin
              state  <= S_FINISH;
              done   <= 1'b1;
              short  <= 1'b0;
              remain <= 8'd0;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            coin       <= sel_code;
            coin_valid <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            state  <= S_FINISH;
            done   <= 1'b1;
            short  <= (rem != 8'd0);
            remain <= rem;
          end
        end
        S_ISSUE: begin
          // Selection guaranteed value <= rem and stock != 0, so no wrap.
          if (coin_ack) begin
            rem         <= rem - coin_value(coin);
            stock[coin] <= stock[coin] - STOCK_ONE;
            coin_valid  <= 1'b0;
            if (rem == coin_value(coin)) begin
              state  <= S_FINISH;
              done   <= 1'b1;
              short  <= 1'b0;
              remain <= 8'd0;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: one instance with the default stock
// of 8 and one with a stock of 1, driven by a vector table, hand-written
// reset/refill sequences and randomized transactions against a greedy
// payout model.
module tb_vending_change_dispenser;

  logic       clk = 1'b0;
  logic       rst        [2];
  logic [7:0] amt        [2];
  logic       amt_valid  [2];
  logic       amt_ready  [2];
  logic       refill     [2];
  logic [1:0] coin       [2];
  logic       coin_valid [2];
  logic       coin_ack   [2];
  logic       done       [2];
  logic       sh         [2];
  logic [7:0] remain     [2];

  int npass = 0;
  int ntot  = 0;

  int val     [4] = '{1, 5, 10, 50};
  int init_of [2] = '{8, 1};
  int mstock  [2][4];

  always #5 clk = ~clk;

  vending_change_dispenser #(.INIT_STOCK(8), .STOCK_W(8)) dut0 (
    .clk(clk), .rst(rst[0]), .amt(amt[0]), .amt_valid(amt_valid[0]),
    .amt_ready(amt_ready[0]), .refill(refill[0]), .coin(coin[0]),
    .coin_valid(coin_valid[0]), .coin_ack(coin_ack[0]), .done(done[0]),
    .short(sh[0]), .remain(remain[0])
  );

  vending_change_dispenser #(.INIT_STOCK(1), .STOCK_W(8)) dut1 (
    .clk(clk), .rst(rst[1]), .amt(amt[1]), .amt_valid(amt_valid[1]),
    .amt_ready(amt_ready[1]), .refill(refill[1]), .coin(coin[1]),
    .coin_valid(coin_valid[1]), .coin_ack(coin_ack[1]), .done(done[1]),
    .short(sh[1]), .remain(remain[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One full transaction on instance idx, entered and left at a negedge
  // with the DUT idle. stall<0: random ack delay 0..3 per coin; stall=0:
  // coin_ack tied high; stall>0: that many withheld cycles per coin.
  task automatic txn(input int idx, input int a, input bit rf, input int stall,
                     output int got_short, output int got_rem);
    int  q[$];
    int  r, k, lat, stalls_left, tot_stall, held, ncoin;
    bit  prev_cv, fin, pick;
    if (rf) for (int d = 0; d < 4; d++) mstock[idx][d] = init_of[idx];
    r = a;
    pick = 1'b1;
    while (pick) begin
      pick = 1'b0;
      for (int d = 3; d >= 0; d--) begin
        if (!pick && val[d] <= r && mstock[idx][d] > 0) begin
          pick = 1'b1;
          q.push_back(d);
          r -= val[d];
          mstock[idx][d]--;
        end
      end
    end
    k = q.size();

    chk("ready_before_accept", int'(amt_ready[idx]), 1);
    amt[idx]       = 8'(a);
    amt_valid[idx] = 1'b1;
    refill[idx]    = rf;
    coin_ack[idx]  = (stall == 0);
    @(posedge clk);
    @(negedge clk);

    fin = 1'b0; prev_cv = 1'b0; tot_stall = 0; stalls_left = 0;
    ncoin = 0; held = 0; lat = 0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (coin_valid[idx]) begin
        if (!prev_cv) begin
          chk("coin_code", int'(coin[idx]), (q.size() > 0) ? q[0] : -1);
          if (q.size() > 0) void'(q.pop_front());
          ncoin++;
          held = int'(coin[idx]);
          stalls_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end else begin
          chk("coin_stable", int'(coin[idx]), held);
        end
        if (stalls_left > 0) begin
          coin_ack[idx] = 1'b0;
          stalls_left--;
          tot_stall++;
        end else begin
          coin_ack[idx] = 1'b1;
        end
      end else if (stall != 0) begin
        coin_ack[idx] = 1'($urandom_range(0, 1));
      end
      prev_cv = coin_valid[idx];
      if (done[idx]) begin
        fin = 1'b1;
        lat = cyc;
      end
      // Activity on the request side while busy must be ignored.
      if (!fin) begin
        amt_valid[idx] = 1'($urandom_range(0, 1));
        refill[idx]    = 1'($urandom_range(0, 1));
        amt[idx]       = 8'($urandom_range(0, 255));
      end else begin
        amt_valid[idx] = 1'b0;
        refill[idx]    = 1'b0;
      end
    end
    amt_valid[idx] = 1'b0;
    refill[idx]    = 1'b0;

    chk("done_seen", int'(fin), 1);
    got_short = int'(sh[idx]);
    got_rem   = int'(remain[idx]);
    if (fin) begin
      chk("coins_issued", ncoin, k);
      chk("done_latency", lat, 2 * k + 1 + ((r != 0) ? 1 : 0) + tot_stall);
      chk("short", int'(sh[idx]), (r != 0) ? 1 : 0);
      chk("remain", int'(remain[idx]), r);
      chk("ready_low_at_done", int'(amt_ready[idx]), 0);
    end
    @(negedge clk);
    chk("done_one_cycle", int'(done[idx]), 0);
    chk("ready_after_done", int'(amt_ready[idx]), 1);
    coin_ack[idx] = 1'b0;
  endtask

  typedef struct {
    int idx;
    int a;
    bit rf;
    int stall;
    int es;
    int er;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int gs, gr, seen;

    tbl[0] = '{idx: 0, a: 65,  rf: 1'b0, stall: 0, es: 0, er: 0};
    tbl[1] = '{idx: 0, a: 0,   rf: 1'b0, stall: 0, es: 0, er: 0};
    tbl[2] = '{idx: 0, a: 50,  rf: 1'b0, stall: 5, es: 0, er: 0};
    tbl[3] = '{idx: 1, a: 120, rf: 1'b0, stall: 0, es: 1, er: 54};
    tbl[4] = '{idx: 1, a: 3,   rf: 1'b0, stall: 0, es: 1, er: 3};
    tbl[5] = '{idx: 1, a: 66,  rf: 1'b1, stall: 0, es: 0, er: 0};
    tbl[6] = '{idx: 1, a: 66,  rf: 1'b0, stall: 0, es: 1, er: 66};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; amt[i] = 8'd0; amt_valid[i] = 1'b0;
      refill[i] = 1'b0; coin_ack[i] = 1'b0;
      for (int d = 0; d < 4; d++) mstock[i][d] = init_of[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", int'(amt_ready[i]), 1);
      chk("rst_coin_valid", int'(coin_valid[i]), 0);
      chk("rst_coin", int'(coin[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_short", int'(sh[i]), 0);
      chk("rst_remain", int'(remain[i]), 0);
      rst[i] = 1'b0;
    end
    @(negedge clk);

    // Directed vectors with hand-derived outcomes.
    for (int i = 0; i < 7; i++) begin
      txn(tbl[i].idx, tbl[i].a, tbl[i].rf, tbl[i].stall, gs, gr);
      chk("vec_short", gs, tbl[i].es);
      chk("vec_remain", gr, tbl[i].er);
    end

    // Reset while a coin is presented: coin withdrawn, no done, stock restored.
    txn(1, 60, 1'b1, 0, gs, gr);
    amt[1] = 8'd5; amt_valid[1] = 1'b1; coin_ack[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    amt_valid[1] = 1'b0;
    for (int c = 0; c < 10 && !coin_valid[1]; c++) @(negedge clk);
    chk("rst_mid_reached_issue", int'(coin_valid[1]), 1);
    chk("rst_mid_coin", int'(coin[1]), 1);
    rst[1] = 1'b1; amt_valid[1] = 1'b1; amt[1] = 8'd9; refill[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_coin_valid", int'(coin_valid[1]), 0);
    chk("rst_mid_ready", int'(amt_ready[1]), 1);
    chk("rst_mid_done", int'(done[1]), 0);
    @(negedge clk);
    rst[1] = 1'b0; amt_valid[1] = 1'b0;
    for (int d = 0; d < 4; d++) mstock[1][d] = init_of[1];
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[1] || coin_valid[1]) seen = 1;
    end
    chk("rst_mid_quiet", seen, 0);
    txn(1, 50, 1'b0, 0, gs, gr);
    chk("rst_mid_restored_short", gs, 0);

    // Randomized transactions on both instances against the model.
    for (int n = 0; n < 60; n++) begin
      txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 5) == 0), -1, gs, gr);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/vending_change_dispenser.md
# vending_change_dispenser

Coin-payout engine that sits on the output side of the vending controller. It takes the 8-bit change amount the controller reports and issues physical coins one at a time to a coin-ejector mechanism, largest denomination first. It tracks a per-denomination coin stock and reports any amount it could not pay.

## Interface
- INIT_STOCK, 8 — coins loaded per denomination at reset and on refill
- STOCK_W, 8 — width of each stock counter; INIT_STOCK must fit

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- amt  in  8  change amount to pay, unsigned, units of 1
- amt_valid  in  1  amt is valid; transaction accepted when amt_valid & amt_ready at a rising edge
- amt_ready  out  1  high exactly when state is IDLE
- refill  in  1  reload all four stocks to INIT_STOCK; honoured only in IDLE
- coin  out  2  denomination code: 0=1, 1=5, 2=10, 3=50
- coin_valid  out  1  coin presented to ejector; held with coin stable until coin_ack
- coin_ack  in  1  ejector consumed the presented coin; ignored when coin_valid=0
- done  out  1  one-cycle pulse marking transaction end
- short  out  1  valid with done: 1 if remain != 0
- remain  out  8  unpaid amount; updated with done, held until next done

## Operation
- FSM states: IDLE, SELECT, ISSUE, FINISH.
- IDLE: on accept, latch rem = amt. If amt == 0, go to FINISH; otherwise go to SELECT. Refill in the same cycle as an accept is applied first, so SELECT sees the full stock.
- SELECT: pick the largest denomination d with value(d) <= rem and stock[d] != 0.
  - If found: coin <= d, coin_valid <= 1, go to ISSUE.
  - If none: go to FINISH.
- ISSUE: hold coin and coin_valid.
  - On coin_ack: rem -= value(coin), stock[coin] -= 1, coin_valid <= 0.
  - Then go to FINISH if the new rem == 0, else go to SELECT.
- FINISH: done = 1, short = (rem != 0), remain = rem. Go to IDLE.
- Arithmetic:
  - rem is 8-bit unsigned and never underflows, because selection guarantees value <= rem.
  - Stock counters never go below 0, because selection requires stock != 0.
- refill outside IDLE is ignored.
- amt_valid outside IDLE is ignored; amt is not sampled.

## Timing
- Reset (edge with rst=1):
  - state IDLE, so amt_ready=1 from the edge after rst rises.
  - coin=0, coin_valid=0, done=0, short=0, remain=0, rem=0.
  - All stocks = INIT_STOCK.
- While rst=1, all inputs are ignored.
- Reset mid-operation aborts the transaction. The presented coin is withdrawn (coin_valid=0 after the edge) and no done is issued.
- Accept edge T, amt=0: done at cycle T+1, amt_ready=1 at T+2.
- Per coin with coin_ack tied high: 2 cycles (SELECT, ISSUE). For k coins, done is in cycle T+2k+1.
- Each coin_ack extends ISSUE by one cycle per stalled cycle. coin and coin_valid must not change while stalled.
- done, short and remain are registered outputs. There is no combinational path from any input to any output, except amt_ready = (state == IDLE).

## Structure
- Shared package vending_pkg holds:
  - denomination code typedef (2-bit enum COIN_1/5/10/50)
  - constant value table {1,5,10,50}
  - FSM state enum
- Sub-module vending_coin_select:
  - combinational priority picker
  - inputs: rem and four stock-nonzero flags
  - outputs: found and code
- Top level holds the FSM, rem, stock counters and output registers.

## Test plan
- Reset, then amt=65 with coin_ack=1 → coins 50, 10, 5 in successive ISSUE cycles; done at T+7 with short=0, remain=0; stocks[50,10,5] = INIT_STOCK-1.
- amt=0 → no coin_valid; done at T+1 with short=0, remain=0.
- INIT_STOCK=1, amt=120 → coins 50, 10, 5, 1; done with short=1, remain=54; a second amt=3 gives no coins, done with short=1, remain=3.
- amt=50 with coin_ack withheld 5 cycles → coin=3 and coin_valid stable for 6 cycles; stock decremented only on the ack edge.
- rst asserted in ISSUE → coin_valid=0 and amt_ready=1 after the edge; no done; stocks restored (next amt=50 pays a 50).
- After depletion (INIT_STOCK=1, amt=66 → 50, 10, 5, 1), refill together with amt_valid and amt=66 → same four coins, short=0.
